vga_rx_decoder: RTL and testbench

Receive-side decoder for the ev21g1 VGA output (`vga_hsync`, `vga_vsync`, `vga_rgb`). It recovers pixel coordinates from the sync stream, measures line and frame timing, and runs a lock state machine. It emits a per-pixel strobe with x/y/rgb. It sits on the bench and capture side of the CPU's video port, used for framebuffer capture and on-chip timing checks.

---
 rtl/vga_rx_pkg.sv | 22 ++
 rtl/vga_rx_sync.sv | 63 ++++++
 rtl/vga_rx_decoder.sv | 202 ++++++++++++++++++++
 tb/tb_vga_rx_decoder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_rx_pkg.sv
// Shared types and constants for the VGA receive-side decoder.
package vga_rx_pkg;

    localparam int H_W = 12;
    localparam int V_W = 11;

    localparam logic [H_W-1:0] H_MAX = '1;
    localparam logic [V_W-1:0] V_MAX = '1;

    // 640x480 @ 800x525 total timing
    localparam int DEF_H_START  = 144;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_START  = 35;
    localparam int DEF_V_ACTIVE = 480;

    typedef enum logic [1:0] {
        SEARCH,
        ACQUIRE,
        LOCKED
    } lock_state_e;

endpackage

// File: rtl/vga_rx_sync.sv
// Input synchronizer for the VGA sync/colour inputs. Sync lines are
// normalized to active-high; leading edges are detected against the
// previous decode (pix_ce) sample, not the previous clk.
module vga_rx_sync #(
    parameter int SYNC_STAGES = 2,
    parameter bit SYNC_POL    = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_ce,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [2:0] rgb_in,
    output logic       h_edge,
    output logic       v_edge,
    output logic [2:0] rgb
);

    logic [SYNC_STAGES-1:0]      hs_pipe;
    logic [SYNC_STAGES-1:0]      vs_pipe;
    logic [SYNC_STAGES-1:0][2:0] rgb_pipe;
    logic                        hs_prev;
    logic                        vs_prev;
    logic                        hs;
    logic                        vs;

    // Free-running shift chain; 0 in the sync chains means "deasserted"
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_pipe  <= '0;
            vs_pipe  <= '0;
            rgb_pipe <= '0;
        end else begin
            hs_pipe[0]  <= hsync_in ~^ SYNC_POL;
            vs_pipe[0]  <= vsync_in ~^ SYNC_POL;
            rgb_pipe[0] <= rgb_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                hs_pipe[i]  <= hs_pipe[i-1];
                vs_pipe[i]  <= vs_pipe[i-1];
                rgb_pipe[i] <= rgb_pipe[i-1];
            end
        end
    end

    assign hs  = hs_pipe[SYNC_STAGES-1];
    assign vs  = vs_pipe[SYNC_STAGES-1];
    assign rgb = rgb_pipe[SYNC_STAGES-1];

    // Remember the sync level seen at the last decode sample
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_prev <= 1'b0;
            vs_prev <= 1'b0;
        end else if (pix_ce) begin
            hs_prev <= hs;
            vs_prev <= vs;
        end
    end

    assign h_edge = pix_ce & hs & ~hs_prev;
    assign v_edge = pix_ce & vs & ~vs_prev;

endmodule

// File: rtl/vga_rx_decoder.sv
// VGA receive decoder: recovers pixel coordinates from hsync/vsync,
// measures line/frame timing and tracks lock. Define VGA_RX_STATS_EN to
// build the frame/error statistics counters; otherwise they read 0.
module vga_rx_decoder
    import vga_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit SYNC_POL    = 1'b0,
    parameter int H_START     = DEF_H_START,
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_START     = DEF_V_START,
    parameter int V_ACTIVE    = DEF_V_ACTIVE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_ce,
    input  logic        vga_hsync,
    input  logic        vga_vsync,
    input  logic [2:0]  vga_rgb,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [2:0]  pix_rgb,
    output logic        frame_start,
    output logic [11:0] line_len,
    output logic [10:0] frame_lines,
    output logic        locked,
    output logic        sync_err,
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt
);

    localparam logic [H_W-1:0] H_LO = H_W'(H_START);
    localparam logic [H_W-1:0] H_HI = H_W'(H_START + H_ACTIVE);
    localparam logic [V_W-1:0] V_LO = V_W'(V_START);
    localparam logic [V_W-1:0] V_HI = V_W'(V_START + V_ACTIVE);

    logic           h_edge, v_edge;
    logic [2:0]     rgb_s;
    logic [H_W-1:0] h_cnt, h_nxt, len_now, ref_len, ref_len_nxt;
    logic [V_W-1:0] v_cnt, v_nxt, lines_now, ref_lines, ref_lines_nxt;
    logic           ref_set, ref_set_nxt;
    logic           err;
    logic           in_win;
    lock_state_e    state, state_nxt;

    vga_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .SYNC_POL    (SYNC_POL)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .pix_ce   (pix_ce),
        .hsync_in (vga_hsync),
        .vsync_in (vga_vsync),
        .rgb_in   (vga_rgb),
        .h_edge   (h_edge),
        .v_edge   (v_edge),
        .rgb      (rgb_s)
    );

    assign len_now   = h_cnt + H_W'(1);
    assign lines_now = v_cnt + V_W'(1);

    // Counter values this decode sample takes; the edge sample is position 0
    always_comb begin
        h_nxt = h_cnt;
        v_nxt = v_cnt;
        if (pix_ce) begin
            if (h_edge)
                h_nxt = '0;
            else if (h_cnt != H_MAX)
                h_nxt = len_now;
            if (v_edge)
                v_nxt = '0;
            else if (h_edge && v_cnt != V_MAX)
                v_nxt = lines_now;
        end
    end

    assign in_win = (h_nxt >= H_LO) && (h_nxt < H_HI) &&
                    (v_nxt >= V_LO) && (v_nxt < V_HI);

    // Position counters and last-measured line/frame lengths
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            line_len    <= '0;
            frame_lines <= '0;
        end else begin
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
            if (h_edge) line_len    <= len_now;
            if (v_edge) frame_lines <= lines_now;
        end
    end

    // Lock FSM: learn line length in ACQUIRE, frame length on entry to LOCKED
    always_comb begin
        state_nxt     = state;
        ref_set_nxt   = ref_set;
        ref_len_nxt   = ref_len;
        ref_lines_nxt = ref_lines;
        err           = 1'b0;
        unique case (state)
            SEARCH: begin
                if (v_edge) begin
                    state_nxt   = ACQUIRE;
                    ref_set_nxt = 1'b0;
                end
            end
            ACQUIRE: begin
                if (h_edge) begin
                    if (!ref_set) begin
                        ref_len_nxt = len_now;
                        ref_set_nxt = 1'b1;
                    end else if (len_now != ref_len) begin
                        state_nxt = SEARCH;
                    end
                end
                // A frame without any completed reference line cannot lock
                if (v_edge && state_nxt == ACQUIRE) begin
                    if (ref_set) begin
                        state_nxt     = LOCKED;
                        ref_lines_nxt = lines_now;
                    end else begin
                        state_nxt = SEARCH;
                    end
                end
            end
            LOCKED: begin
                if (h_edge && len_now != ref_len)     err = 1'b1;
                if (v_edge && lines_now != ref_lines) err = 1'b1;
                if (h_nxt == H_MAX || v_nxt == V_MAX) err = 1'b1;
                if (err) state_nxt = SEARCH;
            end
            default: state_nxt = SEARCH;
        endcase
    end

    // Lock state and reference registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SEARCH;
            ref_set   <= 1'b0;
            ref_len   <= '0;
            ref_lines <= '0;
        end else begin
            state     <= state_nxt;
            ref_set   <= ref_set_nxt;
            ref_len   <= ref_len_nxt;
            ref_lines <= ref_lines_nxt;
        end
    end

    assign locked = (state == LOCKED);

    // Pixel strobe and event pulses; pixel fields hold between strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_rgb     <= '0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            pix_valid   <= pix_ce && in_win && (state_nxt == LOCKED);
            frame_start <= v_edge && (state_nxt == LOCKED);
            sync_err    <= err;
            if (pix_ce && in_win && state_nxt == LOCKED) begin
                pix_x   <= 10'(h_nxt - H_LO);
                pix_y   <= 10'(v_nxt - V_LO);
                pix_rgb <= rgb_s;
            end
        end
    end

`ifdef VGA_RX_STATS_EN
    logic [15:0] fc;
    logic [7:0]  ec;

    // Frame counter wraps, error counter saturates
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fc <= '0;
            ec <= '0;
        end else begin
            if (frame_start)              fc <= fc + 16'd1;
            if (sync_err && ec != 8'hFF)  ec <= ec + 8'd1;
        end
    end

    assign frame_cnt = fc;
    assign err_cnt   = ec;
`else
    assign frame_cnt = '0;
    assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_vga_rx_decoder.sv
// Directed bench for vga_rx_decoder using a reduced 20x8 raster
// (hsync 3 clks, vsync 2 lines, active 8x3 starting at h=4, v=2).
module tb_vga_rx_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_ce;
    logic        vga_hsync;
    logic        vga_vsync;
    logic [2:0]  vga_rgb;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [2:0]  pix_rgb;
    logic        frame_start;
    logic [11:0] line_len;
    logic [10:0] frame_lines;
    logic        locked;
    logic        sync_err;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    vga_rx_decoder #(
        .SYNC_STAGES (2),
        .SYNC_POL    (1'b0),
        .H_START     (4),
        .H_ACTIVE    (8),
        .V_START     (2),
        .V_ACTIVE    (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pix_ce      (pix_ce),
        .vga_hsync   (vga_hsync),
        .vga_vsync   (vga_vsync),
        .vga_rgb     (vga_rgb),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_rgb     (pix_rgb),
        .frame_start (frame_start),
        .line_len    (line_len),
        .frame_lines (frame_lines),
        .locked      (locked),
        .sync_err    (sync_err),
        .frame_cnt   (frame_cnt),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int nlines;
        int short_idx;
        bit tog;
        int exp_valid;
        int exp_fs;
        int exp_err;
        bit exp_locked;
        int exp_len;
        int exp_lines;
    } row_t;

    int n_tests = 0;
    int n_fail  = 0;

    // monitor state
    int n_valid = 0, n_fs = 0, n_err = 0, n_bad = 0;
    int fx = 0, fy = 0, frgb = 0, lx = 0, ly = 0, lrgb = 0;
    bit want_first = 1'b0;
    bit mon_ce;

    int fs_base = 0, err_base = 0;
    bit [1:0] ce_q = 2'b11;

    // Count strobes/pulses; a strobe is bad if pix_ce was low at its edge
    always @(posedge clk) begin
        mon_ce = pix_ce;
        #1;
        if (pix_valid) begin
            n_valid++;
            if (!mon_ce) n_bad++;
            if (want_first) begin
                fx = pix_x; fy = pix_y; frgb = pix_rgb;
                want_first = 1'b0;
            end
            lx = pix_x; ly = pix_y; lrgb = pix_rgb;
        end
        if (frame_start) begin
            n_fs++;
            want_first = 1'b1;
        end
        if (sync_err) n_err++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // pix_ce is aligned to the sample it will decode, SYNC_STAGES clks later
    task automatic tick(input bit hs, input bit vs, input logic [2:0] rgb, input bit flag);
        vga_hsync = ~hs;
        vga_vsync = ~vs;
        vga_rgb   = rgb;
        pix_ce    = ce_q[1];
        ce_q      = {ce_q[0], flag};
        @(posedge clk);
        #2;
    endtask

    task automatic send_line(input int len, input bit vs, input bit tog, input int from);
        for (int i = from; i < len; i++) begin
            logic [2:0] c;
            c = 3'(i);
            tick(i < 3, vs, c, 1'b1);
            if (tog) tick(i < 3, vs, c, 1'b0);
        end
    endtask

    task automatic send_frame(input int nlines, input int short_idx, input bit tog);
        for (int l = 0; l < nlines; l++)
            send_line((l == short_idx) ? 19 : 20, l < 2, tog, 0);
    endtask

    task automatic check_zero(input string p);
        chk({p, "_pix"},   {8'd0, pix_valid, pix_x, pix_y, pix_rgb}, 32'd0);
        chk({p, "_meas"},  {9'd0, line_len, frame_lines}, 32'd0);
        chk({p, "_flags"}, {29'd0, frame_start, locked, sync_err}, 32'd0);
        chk({p, "_stats"}, {8'd0, frame_cnt, err_cnt}, 32'd0);
    endtask

    task automatic check_stats(input string p);
`ifdef VGA_RX_STATS_EN
        int e;
        e = n_err - err_base;
        chk({p, "_frame_cnt"}, frame_cnt, (n_fs - fs_base) & 16'hFFFF);
        chk({p, "_err_cnt"}, err_cnt, (e > 255) ? 255 : e);
`else
        chk({p, "_frame_cnt"}, frame_cnt, 0);
        chk({p, "_err_cnt"}, err_cnt, 0);
`endif
    endtask

    initial begin
        row_t rows[9];
        int v0, f0, e0;

        rows[0] = '{8, -1, 1'b0, 24, 1, 0, 1'b1, 20, 8};  // nominal
        rows[1] = '{8, -1, 1'b1, 24, 1, 0, 1'b1, 20, 8};  // pix_ce toggling
        rows[2] = '{8,  5, 1'b0, 24, 1, 1, 1'b0, 20, 8};  // one 19-clk line
        rows[3] = '{8, -1, 1'b0,  0, 0, 0, 1'b0, 20, 8};  // SEARCH -> ACQUIRE
        rows[4] = '{8, -1, 1'b0, 24, 1, 0, 1'b1, 20, 8};  // relocked
        rows[5] = '{9, -1, 1'b0, 24, 1, 0, 1'b1, 20, 8};  // 9-line frame
        rows[6] = '{8, -1, 1'b0,  0, 0, 1, 1'b0, 20, 9};  // frame count miss
        rows[7] = '{8, -1, 1'b0,  0, 0, 0, 1'b0, 20, 8};  // ACQUIRE
        rows[8] = '{8, -1, 1'b1, 24, 1, 0, 1'b1, 20, 8};  // relock, toggling

        reset = 1'b1; pix_ce = 1'b0;
        vga_hsync = 1'b1; vga_vsync = 1'b1; vga_rgb = '0;
        #3;
        check_zero("reset");
        tick(0, 0, 3'd0, 1'b1);
        tick(0, 0, 3'd0, 1'b1);
        reset = 1'b0;
        fs_base = n_fs; err_base = n_err;

        // first frame only reaches ACQUIRE
        f0 = n_fs;
        send_frame(8, -1, 1'b0);
        chk("lock_after_1st_vsync", locked, 0);
        chk("fs_before_lock", n_fs - f0, 0);

        // second vsync edge: lock exactly when the coincident edge decodes
        v0 = n_valid; e0 = n_err;
        tick(1, 1, 3'd0, 1'b1);
        tick(1, 1, 3'd1, 1'b1);
        chk("lock_before_2nd_edge", locked, 0);
        tick(1, 1, 3'd2, 1'b1);
        chk("lock_at_2nd_edge", locked, 1);
        chk("coincident_h_cnt", dut.h_cnt, 0);
        chk("coincident_v_cnt", dut.v_cnt, 0);
        chk("fs_on_lock_edge", n_fs - f0, 1);
        send_line(20, 1'b1, 1'b0, 3);
        for (int l = 1; l < 8; l++) send_line(20, l < 2, 1'b0, 0);
        chk("frame2_strobes", n_valid - v0, 24);
        chk("frame2_no_err", n_err - e0, 0);
        chk("line_len", line_len, 20);
        chk("frame_lines", frame_lines, 8);
        chk("first_xy", fx * 256 + fy, 0);
        chk("first_rgb", frgb, 4);
        chk("last_xy", lx * 256 + ly, 7 * 256 + 2);
        chk("last_rgb", lrgb, 3);
        chk("hold_x", pix_x, 7);
        chk("hold_y", pix_y, 2);
        check_stats("lock");

        // frame-level table
        for (int r = 0; r < 9; r++) begin
            v0 = n_valid; f0 = n_fs; e0 = n_err;
            send_frame(rows[r].nlines, rows[r].short_idx, rows[r].tog);
            chk($sformatf("row%0d_strobes", r), n_valid - v0, rows[r].exp_valid);
            chk($sformatf("row%0d_frame_start", r), n_fs - f0, rows[r].exp_fs);
            chk($sformatf("row%0d_sync_err", r), n_err - e0, rows[r].exp_err);
            chk($sformatf("row%0d_locked", r), locked, rows[r].exp_locked);
            chk($sformatf("row%0d_line_len", r), line_len, rows[r].exp_len);
            chk($sformatf("row%0d_frame_lines", r), frame_lines, rows[r].exp_lines);
        end
        check_stats("table");

        // hsync disappears while locked: timeout at h_cnt = 4095
        e0 = n_err;
        for (int i = 0; i <= 4090; i++) tick(i < 3, 0, 3'(i), 1'b1);
        chk("timeout_not_early", n_err - e0, 0);
        chk("timeout_still_locked", locked, 1);
        for (int i = 4091; i < 5000; i++) tick(0, 0, 3'(i), 1'b1);
        chk("timeout_err_once", n_err - e0, 1);
        chk("timeout_unlocked", locked, 0);
        chk("timeout_h_hold", dut.h_cnt, 4095);
        tick(1, 1, 3'd0, 1'b1);
        tick(1, 1, 3'd1, 1'b1);
        tick(1, 1, 3'd2, 1'b1);
        chk("sat_line_len", line_len, 0);
        send_line(20, 1'b1, 1'b0, 3);
        for (int l = 1; l < 8; l++) send_line(20, l < 2, 1'b0, 0);
        chk("post_timeout_acquire", locked, 0);
        chk("post_timeout_len", line_len, 20);
        send_frame(8, -1, 1'b0);
        chk("post_timeout_relock", locked, 1);
        check_stats("timeout");

        // reset in the middle of an active line
        for (int l = 0; l < 3; l++) send_line(20, l < 2, 1'b0, 0);
        v0 = n_valid;
        send_line(8, 1'b0, 1'b0, 0);
        chk("midline_strobing", n_valid - v0, 2);
        #3;
        reset = 1'b1;
        #1;
        check_zero("midrst");
        tick(0, 0, 3'd0, 1'b1);
        tick(0, 0, 3'd0, 1'b1);
        reset = 1'b0;
        fs_base = n_fs; err_base = n_err;
        send_frame(8, -1, 1'b0);
        chk("midrst_after_1_vsync", locked, 0);
        send_frame(8, -1, 1'b0);
        chk("midrst_after_2_vsync", locked, 1);
        check_stats("midrst");

        chk("strobe_without_ce", n_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
